// File: rtl/ricevitore_seriale_pkg.sv
// ricevitore_seriale_pkg
//   Shared definitions for the serial receiver: receiver FSM state type,
//   default frame geometry and a width helper for the bit-timing counter.
package ricevitore_seriale_pkg;

  // Default frame geometry: data bits per frame and ck cycles per serial bit.
  localparam int unsigned N_BIT_DEF      = 8;
  localparam int unsigned CK_PER_BIT_DEF = 4;

  // Receiver FSM states. The encodings match the legacy state values.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATI  = 2'd2,
    S_STOP  = 2'd3
  } stato_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned larghezza(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ricevitore_seriale_if.sv
// ricevitore_seriale_if
//   Groups the serial line and the parallel-word outputs of the receiver.
//   Signals:
//     d             serial line (idle 1), driven by the upstream flip-flop stage
//     dato          last correctly received word
//     valido        1-cycle pulse: dato just updated with a good frame
//     errore_frame  1-cycle pulse: stop bit sampled 0, frame discarded
//     occupato      1 while a frame is being received
//   Modports:
//     master  line source / word consumer side
//     slave   receiver side
interface ricevitore_seriale_if #(
  parameter int unsigned N_BIT = 8
);

  logic             d;
  logic [N_BIT-1:0] dato;
  logic             valido;
  logic             errore_frame;
  logic             occupato;

  modport master (
    output d,
    input  dato,
    input  valido,
    input  errore_frame,
    input  occupato
  );

  modport slave (
    input  d,
    output dato,
    output valido,
    output errore_frame,
    output occupato
  );

endinterface

// File: rtl/ricevitore_seriale_temporizzatore.sv
// temporizzatore_bit
//   Bit-timing counter for the serial receiver. Counts ck cycles inside the
//   current serial bit and flags the half-bit and full-bit positions.
//   Ports:
//     ck        clock, rising edge
//     reset     synchronous, active-high
//     clr       synchronous clear of the counter (takes effect on this edge)
//     meta_bit  cnt == CK_PER_BIT/2-1 (next edge is the bit midpoint from a start edge)
//     fine_bit  cnt == CK_PER_BIT-1   (next edge closes a full bit period)
module temporizzatore_bit
  import ricevitore_seriale_pkg::*;
#(
  parameter int unsigned CK_PER_BIT = CK_PER_BIT_DEF
) (
  input  logic ck,
  input  logic reset,
  input  logic clr,
  output logic meta_bit,
  output logic fine_bit
);

  localparam int unsigned   CW       = larghezza(CK_PER_BIT);
  localparam logic [CW-1:0] CNT_META = CW'(CK_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_FINE = CW'(CK_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // The FSM clears the counter whenever it reaches a compare value it acts
  // on, so cnt never runs past CK_PER_BIT-1.
  always_ff @(posedge ck) begin
    if (reset || clr) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign meta_bit = (cnt == CNT_META);
  assign fine_bit = (cnt == CNT_FINE);

endmodule

// File: rtl/ricevitore_seriale.sv
// ricevitore_seriale
//   Serial receiver fed by the negative-edge flip-flop stage. Frame format:
//   idle-high line, start bit 0, N_BIT data bits LSB first, stop bit 1; each
//   bit lasts CK_PER_BIT ck cycles. The start bit is confirmed at its midpoint
//   and every following bit is sampled one full bit period later, i.e. at its
//   own midpoint. Good frames update dato and pulse valido; a stop bit sampled
//   low pulses errore_frame and leaves dato unchanged.
//   Ports:
//     ck     clock, all state updates on rising edge
//     reset  synchronous, active-high; drops any partial frame without a pulse
//     bus    ricevitore_seriale_if.slave (d in; dato, valido, errore_frame,
//            occupato out, all registered)
module ricevitore_seriale
  import ricevitore_seriale_pkg::*;
#(
  parameter int unsigned N_BIT      = N_BIT_DEF,
  parameter int unsigned CK_PER_BIT = CK_PER_BIT_DEF
) (
  input logic                 ck,
  input logic                 reset,
  ricevitore_seriale_if.slave bus
);

  localparam int unsigned   IW       = $clog2(N_BIT) + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N_BIT - 1);

  stato_t           stato;
  stato_t           stato_n;

  logic             meta_bit;
  logic             fine_bit;
  logic             tmr_clr;

  logic             campiona;   // sample d into the data bit at idx
  logic             frame_ok;   // stop bit sampled 1
  logic             frame_ko;   // stop bit sampled 0

  logic [IW-1:0]    idx;
  logic [N_BIT-1:0] sreg;
  logic [N_BIT-1:0] dato_q;
  logic             valido_q;
  logic             errore_q;
  logic             occupato_q;

  temporizzatore_bit #(
    .CK_PER_BIT(CK_PER_BIT)
  ) u_temporizzatore (
    .ck       (ck),
    .reset    (reset),
    .clr      (tmr_clr),
    .meta_bit (meta_bit),
    .fine_bit (fine_bit)
  );

  // State register.
  always_ff @(posedge ck) begin
    if (reset) begin
      stato <= S_IDLE;
    end else begin
      stato <= stato_n;
    end
  end

  // Next state and per-cycle strobes.
  always_comb begin
    stato_n  = stato;
    tmr_clr  = 1'b0;
    campiona = 1'b0;
    frame_ok = 1'b0;
    frame_ko = 1'b0;
    unique case (stato)
      S_IDLE: begin
        // Hold the counter at 0 so that it is aligned with the start edge.
        tmr_clr = 1'b1;
        if (!bus.d) begin
          stato_n = S_START;
        end
      end
      S_START: begin
        if (meta_bit) begin
          // Line back high at the start-bit midpoint: glitch, no pulse.
          tmr_clr = 1'b1;
          stato_n = bus.d ? S_IDLE : S_DATI;
        end
      end
      S_DATI: begin
        if (fine_bit) begin
          tmr_clr  = 1'b1;
          campiona = 1'b1;
          if (idx == IDX_LAST) begin
            stato_n = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (fine_bit) begin
          // Leave at the stop-bit midpoint so a back-to-back start is caught.
          tmr_clr  = 1'b1;
          stato_n  = S_IDLE;
          frame_ok = bus.d;
          frame_ko = !bus.d;
        end
      end
      default: begin
        stato_n = S_IDLE;
      end
    endcase
  end

  // Bit index, shift register and registered outputs.
  always_ff @(posedge ck) begin
    if (reset) begin
      idx        <= '0;
      sreg       <= '0;
      dato_q     <= '0;
      valido_q   <= 1'b0;
      errore_q   <= 1'b0;
      occupato_q <= 1'b0;
    end else begin
      // idx is only consumed in DATI; clearing it for the whole START phase
      // is equivalent to clearing it on the START->DATI transition.
      if (stato == S_START) begin
        idx <= '0;
      end else if (campiona && (idx != IDX_LAST)) begin
        idx <= idx + IW'(1);
      end

      // Write the sampled bit at position idx (LSB first); the compare loop
      // avoids indexing sreg with the one-bit-wider idx.
      if (campiona) begin
        for (int unsigned i = 0; i < N_BIT; i++) begin
          if (idx == IW'(i)) begin
            sreg[i] <= bus.d;
          end
        end
      end

      if (frame_ok) begin
        dato_q <= sreg;
      end
      valido_q   <= frame_ok;
      errore_q   <= frame_ko;
      // occupato is registered together with the state it reflects.
      occupato_q <= (stato_n != S_IDLE);
    end
  end

  assign bus.dato         = dato_q;
  assign bus.valido       = valido_q;
  assign bus.errore_frame = errore_q;
  assign bus.occupato     = occupato_q;

endmodule

// File: tb/tb_ricevitore_seriale.sv
`timescale 1ns/1ps
module tb_ricevitore_seriale;

  localparam int unsigned N_BIT      = 8;
  localparam int unsigned CK_PER_BIT = 4;
  // Cycles from the first edge seeing the start bit to the stop-bit sample.
  localparam int unsigned LAT        = CK_PER_BIT / 2 + (N_BIT + 1) * CK_PER_BIT;

  typedef struct packed {
    int unsigned      cyc;
    logic             err;
    logic [N_BIT-1:0] dato;
  } ev_t;

  logic ck    = 1'b0;
  logic reset = 1'b1;

  ricevitore_seriale_if #(.N_BIT(N_BIT)) bus ();

  ricevitore_seriale #(
    .N_BIT      (N_BIT),
    .CK_PER_BIT (CK_PER_BIT)
  ) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus)
  );

  always #10 ck = ~ck;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned occ_cnt = 0;
  ev_t         obs[$];
  logic [N_BIT-1:0] last_good = '0;

  always @(posedge ck) cyc <= cyc + 1;

  // Monitor: log every cycle with a pulse, count occupato cycles.
  always @(negedge ck) begin
    if (bus.occupato === 1'b1) occ_cnt++;
    if (bus.valido === 1'b1 || bus.errore_frame === 1'b1) begin
      obs.push_back('{cyc: cyc, err: bus.errore_frame, dato: bus.dato});
      n_checks++;
      if (bus.valido === 1'b1 && bus.errore_frame === 1'b1)
        $display("FAIL pulse_exclusive: valido=1 errore_frame=1 at cycle %0d, required not both", cyc);
      else
        n_pass++;
    end
  end

  // Reference model: frame outcome from its content and start-edge cycle.
  function automatic ev_t predict(input int unsigned e0, input logic [N_BIT-1:0] w,
                                  input logic stop);
    ev_t e;
    e.cyc  = e0 + LAT;
    e.err  = ~stop;
    e.dato = stop ? w : last_good;
    return e;
  endfunction

  task automatic drive_bits(input logic b, input int unsigned n);
    bus.d = b;
    repeat (n) @(negedge ck);
  endtask

  // Must be called right after a negedge.
  task automatic send_frame(input logic [N_BIT-1:0] w, input logic stop,
                            input int unsigned gap, output int unsigned e0);
    e0 = cyc + 1;
    drive_bits(1'b0, CK_PER_BIT);
    for (int unsigned i = 0; i < N_BIT; i++) drive_bits(w[i], CK_PER_BIT);
    drive_bits(stop, CK_PER_BIT);
    drive_bits(1'b1, gap);
  endtask

  task automatic test_reset();
    bus.d = 1'b1;
    reset = 1'b1;
    for (int unsigned i = 0; i < 5; i++) begin
      @(negedge ck);
      n_checks++;
      if ({bus.dato, bus.valido, bus.errore_frame, bus.occupato} !== '0)
        $display("FAIL reset_%0d: dato=%h valido=%b errore=%b occupato=%b, required all 0",
                 i, bus.dato, bus.valido, bus.errore_frame, bus.occupato);
      else
        n_pass++;
      bus.d = ~bus.d;
    end
    bus.d = 1'b1;
    reset = 1'b0;
    last_good = '0;
    repeat (2) @(negedge ck);
  endtask

  task automatic test_frame_ok();
    int unsigned base = obs.size();
    int unsigned o0 = occ_cnt;
    int unsigned e0;
    ev_t exp_q[$];
    send_frame(8'hA5, 1'b1, 2 * CK_PER_BIT, e0);
    exp_q.push_back(predict(e0, 8'hA5, 1'b1));
    last_good = 8'hA5;
    n_checks++;
    if (obs.size() - base != exp_q.size())
      $display("FAIL ok_count: got %0d pulses, required %0d", obs.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (base + i >= obs.size())
        $display("FAIL ok_ev%0d: missing, required cyc=%0d err=%b dato=%h", i, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else if (obs[base + i] !== exp_q[i])
        $display("FAIL ok_ev%0d: got cyc=%0d err=%b dato=%h, required cyc=%0d err=%b dato=%h", i,
                 obs[base + i].cyc, obs[base + i].err, obs[base + i].dato, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else n_pass++;
    end
    n_checks++;
    if (occ_cnt - o0 != LAT)
      $display("FAIL ok_occupato: got %0d busy cycles, required %0d", occ_cnt - o0, LAT);
    else n_pass++;
    n_checks++;
    if (bus.dato !== last_good) $display("FAIL ok_dato: got %h, required %h", bus.dato, last_good);
    else n_pass++;
  endtask

  task automatic test_frame_error();
    int unsigned base = obs.size();
    int unsigned e0;
    ev_t exp_q[$];
    send_frame(8'h3C, 1'b0, CK_PER_BIT + 2, e0);
    exp_q.push_back(predict(e0, 8'h3C, 1'b0));
    n_checks++;
    if (obs.size() - base != exp_q.size())
      $display("FAIL err_count: got %0d pulses, required %0d", obs.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (base + i >= obs.size())
        $display("FAIL err_ev%0d: missing, required cyc=%0d err=%b dato=%h", i, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else if (obs[base + i] !== exp_q[i])
        $display("FAIL err_ev%0d: got cyc=%0d err=%b dato=%h, required cyc=%0d err=%b dato=%h", i,
                 obs[base + i].cyc, obs[base + i].err, obs[base + i].dato, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else n_pass++;
    end
    n_checks++;
    if (bus.dato !== 8'hA5) $display("FAIL err_dato: got %h, required a5", bus.dato);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int unsigned base = obs.size();
    int unsigned o0 = occ_cnt;
    logic exp_occ [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bus.d = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge ck);
      bus.d = 1'b1;
      n_checks++;
      if (bus.occupato !== exp_occ[i])
        $display("FAIL glitch_occ%0d: got %b, required %b", i, bus.occupato, exp_occ[i]);
      else n_pass++;
    end
    repeat (2) @(negedge ck);
    n_checks++;
    if (occ_cnt - o0 != 2) $display("FAIL glitch_busy: got %0d cycles, required 2", occ_cnt - o0);
    else n_pass++;
    n_checks++;
    if (obs.size() != base) $display("FAIL glitch_pulse: got %0d pulses, required 0", obs.size() - base);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned base = obs.size();
    int unsigned e0;
    ev_t exp_q[$];
    send_frame(8'h00, 1'b1, 0, e0);
    exp_q.push_back(predict(e0, 8'h00, 1'b1));
    last_good = 8'h00;
    send_frame(8'hFF, 1'b1, 2 * CK_PER_BIT, e0);
    exp_q.push_back(predict(e0, 8'hFF, 1'b1));
    last_good = 8'hFF;
    n_checks++;
    if (obs.size() - base != exp_q.size())
      $display("FAIL b2b_count: got %0d pulses, required %0d", obs.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (base + i >= obs.size())
        $display("FAIL b2b_ev%0d: missing, required cyc=%0d err=%b dato=%h", i, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else if (obs[base + i] !== exp_q[i])
        $display("FAIL b2b_ev%0d: got cyc=%0d err=%b dato=%h, required cyc=%0d err=%b dato=%h", i,
                 obs[base + i].cyc, obs[base + i].err, obs[base + i].dato, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_frame();
    int unsigned base = obs.size();
    int unsigned e0;
    ev_t exp_q[$];
    logic [N_BIT-1:0] w = 8'h5A;
    drive_bits(1'b0, CK_PER_BIT);
    for (int unsigned i = 0; i < 4; i++) drive_bits(w[i], CK_PER_BIT);
    drive_bits(w[4], 2);
    reset = 1'b1;
    @(negedge ck);
    reset = 1'b0;
    bus.d = 1'b1;
    n_checks++;
    if ({bus.dato, bus.valido, bus.errore_frame, bus.occupato} !== '0)
      $display("FAIL midrst_out: dato=%h valido=%b errore=%b occupato=%b, required all 0",
               bus.dato, bus.valido, bus.errore_frame, bus.occupato);
    else n_pass++;
    last_good = '0;
    repeat (CK_PER_BIT) @(negedge ck);
    send_frame(8'h81, 1'b1, 2 * CK_PER_BIT, e0);
    exp_q.push_back(predict(e0, 8'h81, 1'b1));
    last_good = 8'h81;
    n_checks++;
    if (obs.size() - base != exp_q.size())
      $display("FAIL midrst_count: got %0d pulses, required %0d", obs.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (base + i >= obs.size())
        $display("FAIL midrst_ev%0d: missing, required cyc=%0d err=%b dato=%h", i, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else if (obs[base + i] !== exp_q[i])
        $display("FAIL midrst_ev%0d: got cyc=%0d err=%b dato=%h, required cyc=%0d err=%b dato=%h", i,
                 obs[base + i].cyc, obs[base + i].err, obs[base + i].dato, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int unsigned base = obs.size();
    int unsigned e0;
    int unsigned gap;
    logic [N_BIT-1:0] w;
    logic stop;
    ev_t exp_q[$];
    for (int unsigned f = 0; f < 24; f++) begin
      w    = N_BIT'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      // After a low stop bit the line must idle long enough for the
      // receiver to reject the false start it sees there.
      gap  = stop ? $urandom_range(0, 6) : $urandom_range(CK_PER_BIT, CK_PER_BIT + 4);
      if (f == 23) gap = 2 * CK_PER_BIT;
      send_frame(w, stop, gap, e0);
      exp_q.push_back(predict(e0, w, stop));
      if (stop) last_good = w;
    end
    n_checks++;
    if (obs.size() - base != exp_q.size())
      $display("FAIL rnd_count: got %0d pulses, required %0d", obs.size() - base, exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (base + i >= obs.size())
        $display("FAIL rnd_ev%0d: missing, required cyc=%0d err=%b dato=%h", i, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else if (obs[base + i] !== exp_q[i])
        $display("FAIL rnd_ev%0d: got cyc=%0d err=%b dato=%h, required cyc=%0d err=%b dato=%h", i,
                 obs[base + i].cyc, obs[base + i].err, obs[base + i].dato, exp_q[i].cyc, exp_q[i].err, exp_q[i].dato);
      else n_pass++;
    end
    n_checks++;
    if (bus.dato !== last_good) $display("FAIL rnd_dato: got %h, required %h", bus.dato, last_good);
    else n_pass++;
  endtask

  initial begin
    bus.d = 1'b1;
    test_reset();
    test_frame_ok();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
